// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: boot flush, load-use stall, branch flush,
// data-memory wait freeze and halt. Optional stall counter port enabled by `STALL_COUNTER_EN.
module pipeline_hazard_ctrl #(
  parameter int REG_AW       = 5,
  parameter int BOOT_CYCLES  = 2,
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              startin,
  input  logic [REG_AW-1:0] ifid_rs,
  input  logic [REG_AW-1:0] ifid_rt,
  input  logic              ifid_uses_rt,
  input  logic              idex_memread,
  input  logic [REG_AW-1:0] idex_rt,
  input  logic              branch_taken,
  input  logic              mem_busy,
  input  logic              halt_req,
  input  logic              resume,
  output logic              pc_write,
  output logic              pc_src_sel,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              pipe_freeze,
  output logic              halted,
  output logic              mem_timeout
`ifdef STALL_COUNTER_EN
  ,
  output logic [31:0]       stall_count
`endif
);

  localparam int BOOT_W  = (BOOT_CYCLES  > 1) ? $clog2(BOOT_CYCLES  + 1) : 1;
  localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_BOOT    = 3'd0,
    S_RUN     = 3'd1,
    S_FLUSH   = 3'd2,
    S_MEMWAIT = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  state_t              r_state, w_next_state;
  state_t              r_ret_state, w_next_ret;
  state_t              w_dec_state;
  logic [BOOT_W-1:0]   r_boot_cnt, w_next_boot;
  logic [FLUSH_W-1:0]  r_flush_cnt, w_next_flush;
  logic [WAIT_W-1:0]   r_wait_cnt, w_next_wait;
  logic                r_mem_timeout;
  logic                w_set_timeout;
  logic                w_load_use;

  assign w_load_use = idex_memread && (idex_rt != '0) &&
                      ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

  // Once memory goes ready, the cycle is decoded as the state we froze out of, with no lost cycle.
  assign w_dec_state = (r_state == S_MEMWAIT && !mem_busy) ? r_ret_state : r_state;

  assign mem_timeout = r_mem_timeout;

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    pc_write      = 1'b0;
    pc_src_sel    = 1'b0;
    ifid_write    = 1'b0;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    pipe_freeze   = 1'b0;
    halted        = 1'b0;
    w_next_state  = w_dec_state;
    w_next_ret    = r_ret_state;
    w_next_boot   = r_boot_cnt;
    w_next_flush  = r_flush_cnt;
    w_next_wait   = r_wait_cnt;
    w_set_timeout = 1'b0;

    case (w_dec_state)
      S_RUN: begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        if (mem_busy) begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          pipe_freeze  = 1'b1;
          w_next_state = S_MEMWAIT;
          w_next_ret   = S_RUN;
          w_next_wait  = WAIT_W'(1);
        end else if (branch_taken) begin
          pc_src_sel  = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            w_next_state = S_FLUSH;
            w_next_flush = FLUSH_W'(FLUSH_CYCLES - 1);
          end
        end else if (w_load_use) begin
          // The bubble clears idex_memread next cycle, so this stall lasts exactly one cycle.
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end else if (halt_req) begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          idex_bubble  = 1'b1;
          w_next_state = S_HALT;
        end
      end

      S_FLUSH: begin
        if (mem_busy) begin
          pipe_freeze  = 1'b1;
          w_next_state = S_MEMWAIT;
          w_next_ret   = S_FLUSH;
          w_next_wait  = WAIT_W'(1);
        end else begin
          pc_write     = 1'b1;
          ifid_write   = 1'b1;
          ifid_flush   = 1'b1;
          idex_bubble  = 1'b1;
          w_next_flush = r_flush_cnt - FLUSH_W'(1);
          if (r_flush_cnt <= FLUSH_W'(1)) w_next_state = S_RUN;
        end
      end

      S_MEMWAIT: begin
        // Only reached with mem_busy high; the counter stops at MEM_TIMEOUT rather than wrapping.
        pipe_freeze = 1'b1;
        if (r_wait_cnt >= WAIT_W'(MEM_TIMEOUT)) begin
          w_set_timeout = 1'b1;
          w_next_state  = S_HALT;
        end else begin
          w_next_wait = r_wait_cnt + WAIT_W'(1);
        end
      end

      S_HALT: begin
        idex_bubble = 1'b1;
        halted      = 1'b1;
        if (resume && !r_mem_timeout) w_next_state = S_RUN;
      end

      default: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        if (r_state != S_BOOT) begin
          w_next_state = S_BOOT;
          w_next_boot  = '0;
        end else if (r_boot_cnt >= BOOT_W'(BOOT_CYCLES - 1)) begin
          w_next_state = S_RUN;
        end else begin
          w_next_boot = r_boot_cnt + BOOT_W'(1);
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge startin) begin
    if (!startin) begin
      r_state       <= S_BOOT;
      r_ret_state   <= S_RUN;
      r_boot_cnt    <= '0;
      r_flush_cnt   <= '0;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_ret_state   <= w_next_ret;
      r_boot_cnt    <= w_next_boot;
      r_flush_cnt   <= w_next_flush;
      r_wait_cnt    <= w_next_wait;
      r_mem_timeout <= r_mem_timeout | w_set_timeout;
    end
  end

`ifdef STALL_COUNTER_EN
  logic [31:0] r_stall_cnt;
  logic        w_stall_evt;

  assign w_stall_evt = (r_state == S_RUN || r_state == S_FLUSH || r_state == S_MEMWAIT) &&
                       (!pc_write || pipe_freeze);
  assign stall_count = r_stall_cnt;

  always_ff @(posedge clk or negedge startin) begin
    if (!startin) begin
      r_stall_cnt <= '0;
    end else if (w_stall_evt && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: expected output vectors are queued as stimulus is
// driven and compared on the following falling edge.
module tb_pipeline_hazard_ctrl;

  logic       clk;
  logic       startin;
  logic [4:0] ifid_rs, ifid_rt, idex_rt;
  logic       ifid_uses_rt, idex_memread, branch_taken, mem_busy, halt_req, resume;
  logic       pc_write, pc_src_sel, ifid_write, ifid_flush, idex_bubble, pipe_freeze, halted, mem_timeout;
`ifdef STALL_COUNTER_EN
  logic [31:0] stall_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string      tag;
    logic [7:0] exp;
    int         stall_exp;
  } item_t;

  item_t sb_q[$];

  // {pc_write, pc_src_sel, ifid_write, ifid_flush, idex_bubble, pipe_freeze, halted, mem_timeout}
  localparam logic [7:0] E_BOOT    = 8'b0001_1000;
  localparam logic [7:0] E_RUN     = 8'b1010_0000;
  localparam logic [7:0] E_STALL   = 8'b0000_1000;
  localparam logic [7:0] E_BR      = 8'b1111_1000;
  localparam logic [7:0] E_FL      = 8'b1011_1000;
  localparam logic [7:0] E_FRZ     = 8'b0000_0100;
  localparam logic [7:0] E_HALT    = 8'b0000_1010;
  localparam logic [7:0] E_HALT_MT = 8'b0000_1011;

  pipeline_hazard_ctrl #(
    .REG_AW(5), .BOOT_CYCLES(2), .FLUSH_CYCLES(2), .MEM_TIMEOUT(4)
  ) dut (
    .clk(clk), .startin(startin),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .idex_memread(idex_memread), .idex_rt(idex_rt),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .halt_req(halt_req), .resume(resume),
    .pc_write(pc_write), .pc_src_sel(pc_src_sel), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .pipe_freeze(pipe_freeze),
    .halted(halted), .mem_timeout(mem_timeout)
`ifdef STALL_COUNTER_EN
    , .stall_count(stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    item_t it;
    if (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      check(it.tag, {24'd0, pc_write, pc_src_sel, ifid_write, ifid_flush,
                     idex_bubble, pipe_freeze, halted, mem_timeout}, {24'd0, it.exp});
`ifdef STALL_COUNTER_EN
      if (it.stall_exp >= 0) check({it.tag, "_stall_count"}, stall_count, it.stall_exp);
`endif
    end
  end

  // One cycle: drive inputs just after the rising edge, queue the expectation, move to the next edge.
  task automatic cyc(input string tag, input logic rst,
                     input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                     input logic mr, input logic [4:0] xrt,
                     input logic br, input logic busy, input logic hr, input logic rsm,
                     input logic [7:0] exp, input int sexp = -1);
    item_t it;
    startin      = rst;
    ifid_rs      = rs;
    ifid_rt      = rt;
    ifid_uses_rt = uses;
    idex_memread = mr;
    idex_rt      = xrt;
    branch_taken = br;
    mem_busy     = busy;
    halt_req     = hr;
    resume       = rsm;
    it.tag       = tag;
    it.exp       = exp;
    it.stall_exp = sexp;
    sb_q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    startin = 1'b0; ifid_rs = '0; ifid_rt = '0; idex_rt = '0;
    ifid_uses_rt = 1'b0; idex_memread = 1'b0; branch_taken = 1'b0;
    mem_busy = 1'b0; halt_req = 1'b0; resume = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset and boot sequence
    cyc("rst_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_BOOT);
    cyc("boot0",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_BOOT);
    cyc("boot1",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_BOOT);
    cyc("run0",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 0);

    // Load-use on rs, register-0 immunity
    cyc("lu_rs",    1, 5, 0, 0, 1, 5, 0, 0, 0, 0, E_STALL);
    cyc("lu_clear", 1, 5, 0, 0, 0, 5, 0, 0, 0, 0, E_RUN);
    cyc("lu_r0",    1, 0, 0, 0, 1, 0, 0, 0, 0, 0, E_RUN);

    // Three busy cycles then release
    for (int i = 0; i < 3; i++)
      cyc("busy3",  1, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_FRZ);
    cyc("busy_rel", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 4);

    // Load-use on rt, only when rt is a source
    cyc("lu_rt",       1, 3, 7, 1, 1, 7, 0, 0, 0, 0, E_STALL);
    cyc("lu_rt_nouse", 1, 3, 7, 0, 1, 7, 0, 0, 0, 0, E_RUN);

    // Branch over a load-use hazard, FLUSH_CYCLES=2
    cyc("br_lu",    1, 5, 0, 0, 1, 5, 1, 0, 0, 0, E_BR);
    cyc("br_flush", 1, 5, 0, 0, 1, 5, 0, 0, 0, 0, E_FL);
    cyc("br_run",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN);

    // Busy during FLUSH returns to FLUSH
    cyc("br2",      1, 0, 0, 0, 0, 0, 1, 0, 0, 0, E_BR);
    cyc("fl_busy",  1, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_FRZ);
    cyc("fl_back",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_FL);
    cyc("fl_done",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN);

    // Branch beats halt_req
    cyc("br_halt",    1, 0, 0, 0, 0, 0, 1, 0, 1, 0, E_BR);
    cyc("br_halt_fl", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_FL);
    cyc("br_halt_rn", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN);

    // Memory timeout: 4 busy cycles tolerated, the 5th faults into a sticky HALT
    for (int i = 0; i < 5; i++)
      cyc("to_busy",   1, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_FRZ);
    cyc("to_halt",     1, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_HALT_MT);
    cyc("to_noresume", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_HALT_MT);
    cyc("to_rst",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_BOOT);
    cyc("to_boot0",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_BOOT);
    cyc("to_boot1",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_BOOT);
    cyc("to_run",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN);

    // Halt and resume; resume wins over halt_req
    cyc("halt_req",  1, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_STALL);
    cyc("halted",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_HALT);
    cyc("halt_ign",  1, 0, 0, 0, 0, 0, 1, 0, 1, 0, E_HALT);
    cyc("resume",    1, 0, 0, 0, 0, 0, 0, 0, 1, 1, E_HALT);
    cyc("resumed",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN);

    // Reset asserted in the middle of MEMWAIT
    cyc("mw1",    1, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_FRZ);
    cyc("mw2",    1, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_FRZ);
    cyc("mw_rst", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_BOOT);
    cyc("rb0",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_BOOT);
    cyc("rb1",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_BOOT);
    cyc("rb_run", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
